// File: rtl/pool_engine_pkg.sv
// Shared types and elaboration helpers for the streaming pooling engine.
package pool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Accumulator wide enough to hold a full-window sum without overflow.
  function automatic int unsigned acc_w(input int unsigned data_width,
                                        input int unsigned pool_x,
                                        input int unsigned pool_y);
    return data_width + clog2(pool_x * pool_y);
  endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Pixel stream in / pooled stream out handshake bundle.
interface pool_engine_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4
) ();

  logic                         IN_VALID;
  logic                         IN_READY;
  logic [DATA_WIDTH*NUM_PE-1:0] DATA_IN;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic [DATA_WIDTH*NUM_PE-1:0] DATA_OUT;

  modport master (
    output IN_VALID, DATA_IN, OUT_READY,
    input  IN_READY, OUT_VALID, DATA_OUT
  );

  modport slave (
    input  IN_VALID, DATA_IN, OUT_READY,
    output IN_READY, OUT_VALID, DATA_OUT
  );

endinterface

// File: rtl/pool_engine_lane_alu.sv
// Per-lane combine for horizontal and vertical reduction, plus final scale/truncate.
module pool_lane_alu
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_W      = 18,
  parameter int unsigned SHIFT      = 2
) (
  input  logic                  MODE,
  input  logic                  SEED,
  input  logic [ACC_W-1:0]      ACC_H,
  input  logic [DATA_WIDTH-1:0] PIX,
  input  logic                  FIRST_ROW,
  input  logic [ACC_W-1:0]      ACC_V,
  output logic [ACC_W-1:0]      H_OUT,
  output logic [ACC_W-1:0]      V_OUT,
  output logic [DATA_WIDTH-1:0] RES
);

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] scaled;

  function automatic logic [ACC_W-1:0] combine(input logic mode,
                                               input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    if (mode == MODE_AVG) return a + b;
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign pix_ext = ACC_W'($signed(PIX));

  always_comb begin
    H_OUT  = SEED ? pix_ext : combine(MODE, ACC_H, pix_ext);
    V_OUT  = FIRST_ROW ? H_OUT : combine(MODE, ACC_V, H_OUT);
    scaled = (MODE == MODE_AVG) ? ($signed(V_OUT) >>> SHIFT) : $signed(V_OUT);
    RES    = scaled[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/pool_engine.sv
// Streaming non-overlapping POOL_X x POOL_Y max/avg pooling over NUM_PE lanes.
module pool_engine
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned POOL_X     = 2,
  parameter int unsigned POOL_Y     = 2,
  parameter int unsigned MAX_OUT_W  = 32,
  parameter int unsigned DIM_WIDTH  = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [DIM_WIDTH-1:0] CFG_ROW_W,
  input  logic [DIM_WIDTH-1:0] CFG_ROWS,
  input  logic                 CFG_MODE,
  pool_engine_if.slave         bus,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned ACC_W = acc_w(DATA_WIDTH, POOL_X, POOL_Y);
  localparam int unsigned SHIFT = clog2(POOL_X * POOL_Y);
  localparam int unsigned LX    = clog2(POOL_X);
  localparam int unsigned LY    = clog2(POOL_Y);
  localparam int unsigned OXW   = (clog2(MAX_OUT_W) > 0) ? clog2(MAX_OUT_W) : 1;

  localparam logic [DIM_WIDTH-1:0] PX_LAST = DIM_WIDTH'(POOL_X - 1);
  localparam logic [DIM_WIDTH-1:0] PY_LAST = DIM_WIDTH'(POOL_Y - 1);
  localparam logic [DIM_WIDTH-1:0] OX_LIM  = DIM_WIDTH'(MAX_OUT_W);

  state_t                 state;
  logic [DIM_WIDTH-1:0]   row_w, rows, out_w, out_h;
  logic                   mode;
  logic [DIM_WIDTH-1:0]   x, px, ox, py, y;
  logic                   out_valid;
  logic [DATA_WIDTH*NUM_PE-1:0] data_out;

  logic [ACC_W-1:0] hacc [NUM_PE];
  logic [ACC_W-1:0] rbuf [MAX_OUT_W][NUM_PE];
  logic [ACC_W-1:0] h_out [NUM_PE];
  logic [ACC_W-1:0] v_out [NUM_PE];
  logic [DATA_WIDTH*NUM_PE-1:0] res_bus;

  logic                 in_ready;
  logic                 accept;
  logic [DIM_WIDTH-1:0] col_lim, row_lim;
  logic                 in_win, col_end, row_first, row_last, last_x, last_y;
  logic                 win_done, row_done;
  logic [OXW-1:0]       ox_idx;

  assign in_ready  = (state == ST_RUN) && (!out_valid || bus.OUT_READY);
  assign accept    = bus.IN_VALID && in_ready;

  // Windows never straddle the image edge: columns/rows past the last full window are dropped.
  assign col_lim   = out_w << LX;
  assign row_lim   = out_h << LY;
  assign in_win    = (x < col_lim) && (y < row_lim) && (ox < OX_LIM);
  assign col_end   = (px == PX_LAST);
  assign row_first = (py == '0);
  assign row_last  = (py == PY_LAST);
  assign last_x    = (x == row_w - 1'b1);
  assign last_y    = (y == rows - 1'b1);
  assign ox_idx    = ox[OXW-1:0];
  assign row_done  = accept && in_win && col_end;
  assign win_done  = row_done && row_last;

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid;
  assign bus.DATA_OUT  = data_out;

  for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
    pool_lane_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .SHIFT      (SHIFT)
    ) u_alu (
      .MODE      (mode),
      .SEED      (px == '0),
      .ACC_H     (hacc[l]),
      .PIX       (bus.DATA_IN[l*DATA_WIDTH +: DATA_WIDTH]),
      .FIRST_ROW (row_first),
      .ACC_V     (rbuf[ox_idx][l]),
      .H_OUT     (h_out[l]),
      .V_OUT     (v_out[l]),
      .RES       (res_bus[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Datapath storage carries no reset; every window reseeds it before use.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int unsigned l = 0; l < NUM_PE; l++) hacc[l] <= h_out[l];
    end
    if (row_done && !row_last) begin
      for (int unsigned l = 0; l < NUM_PE; l++) rbuf[ox_idx][l] <= v_out[l];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      row_w     <= '0;
      rows      <= '0;
      out_w     <= '0;
      out_h     <= '0;
      mode      <= MODE_MAX;
      x         <= '0;
      px        <= '0;
      ox        <= '0;
      py        <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;

      // Load and drain may coincide, so a completing window never waits a bubble.
      if (win_done) begin
        out_valid <= 1'b1;
        data_out  <= res_bus;
      end else if (bus.OUT_READY) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (START) begin
            row_w <= CFG_ROW_W;
            rows  <= CFG_ROWS;
            mode  <= CFG_MODE;
            out_w <= CFG_ROW_W >> LX;
            out_h <= CFG_ROWS >> LY;
            x     <= '0;
            px    <= '0;
            ox    <= '0;
            py    <= '0;
            y     <= '0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_x) begin
              x  <= '0;
              px <= '0;
              ox <= '0;
              y  <= last_y ? '0 : y + 1'b1;
              py <= row_last ? '0 : py + 1'b1;
              if (last_y) state <= ST_FLUSH;
            end else begin
              x <= x + 1'b1;
              if (col_end) begin
                px <= '0;
                ox <= ox + 1'b1;
              end else begin
                px <= px + 1'b1;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (!out_valid || bus.OUT_READY) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: directed frames plus randomised data/backpressure.
module tb_pool_engine;

  localparam int DW   = 16;
  localparam int NPE  = 4;
  localparam int PX   = 2;
  localparam int PY   = 2;
  localparam int MOW  = 32;
  localparam int DIMW = 10;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            START;
  logic [DIMW-1:0] CFG_ROW_W;
  logic [DIMW-1:0] CFG_ROWS;
  logic            CFG_MODE;
  logic            BUSY;
  logic            DONE;

  pool_engine_if #(.DATA_WIDTH(DW), .NUM_PE(NPE)) bus ();

  pool_engine #(
    .DATA_WIDTH (DW),
    .NUM_PE     (NPE),
    .POOL_X     (PX),
    .POOL_Y     (PY),
    .MAX_OUT_W  (MOW),
    .DIM_WIDTH  (DIMW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .CFG_ROW_W (CFG_ROW_W),
    .CFG_ROWS  (CFG_ROWS),
    .CFG_MODE  (CFG_MODE),
    .bus       (bus),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int pix [16][16][NPE];
  logic [DW*NPE-1:0] exp_q [$];
  logic [DW*NPE-1:0] got_q [$];
  int stalls;
  int done_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // kind 0: pixel index (+1000 per lane), 1: random signed, 2: -(index+1) (-lane)
  task automatic fill(input int w, input int h, input int kind);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        for (int l = 0; l < NPE; l++)
          case (kind)
            0:       pix[yy][xx][l] = yy * w + xx + 1000 * l;
            1:       pix[yy][xx][l] = int'($urandom_range(0, 65535)) - 32768;
            default: pix[yy][xx][l] = -(yy * w + xx + 1) - l;
          endcase
  endtask

  // Reference: enumerate whole windows, max or floor(mean) per lane.
  task automatic build_expected(input int w, input int h, input int avg);
    int ow, oh, s, m, q, v;
    logic [DW*NPE-1:0] beat;
    exp_q.delete();
    ow = w / PX;
    oh = h / PY;
    if (ow > MOW) ow = MOW;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        beat = '0;
        for (int l = 0; l < NPE; l++) begin
          s = 0;
          m = pix[oy*PY][ox*PX][l];
          for (int dy = 0; dy < PY; dy++)
            for (int dx = 0; dx < PX; dx++) begin
              v = pix[oy*PY+dy][ox*PX+dx][l];
              s += v;
              if (v > m) m = v;
            end
          if (avg != 0) begin
            q = s / (PX * PY);
            if ((s % (PX * PY) != 0) && (s < 0)) q = q - 1;
          end else begin
            q = m;
          end
          beat[l*DW +: DW] = q[DW-1:0];
        end
        exp_q.push_back(beat);
      end
  endtask

  function automatic logic [DW*NPE-1:0] beat_data(input int b, input int w);
    logic [DW*NPE-1:0] d;
    int v;
    d = '0;
    for (int l = 0; l < NPE; l++) begin
      v = pix[b / w][b % w][l];
      d[l*DW +: DW] = v[DW-1:0];
    end
    return d;
  endfunction

  task automatic start_frame(input int w, input int h, input int avg);
    CFG_ROW_W = DIMW'(w);
    CFG_ROWS  = DIMW'(h);
    CFG_MODE  = avg[0];
    START     = 1'b1;
    @(posedge CLK); #1;
    START     = 1'b0;
    CFG_ROW_W = 10'd3;
    CFG_ROWS  = 10'd3;
    CFG_MODE  = ~avg[0];
    chk("busy_after_start", 64'(BUSY), 64'd1);
  endtask

  task automatic drive(input int n, input int w, input int vrand);
    bit acc;
    bit ok;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      if (vrand != 0 && $urandom_range(0, 3) == 0) begin
        bus.IN_VALID = 1'b0;
        @(posedge CLK); #1;
      end
      if (b == 3) START = 1'b1;
      bus.IN_VALID = 1'b1;
      bus.DATA_IN  = beat_data(b, w);
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge CLK);
        acc = bus.IN_READY;
        @(posedge CLK); #1;
        if (acc) begin
          ok = 1'b1;
          break;
        end
        stalls++;
      end
      START = 1'b0;
      if (!ok) begin
        chk("in_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  // rmode 0: always ready, 1: hold off 10 cycles once an output is pending, 2: random.
  task automatic collect(input int rmode, input bit chk_lat);
    bit prev_pend;
    logic [DW*NPE-1:0] prev_data;
    int stall_left;
    int last_take;
    int done_cyc;
    prev_pend  = 1'b0;
    prev_data  = '0;
    stall_left = -1;
    last_take  = -100;
    done_cyc   = -100;
    done_cnt   = 0;
    got_q.delete();
    for (int c = 0; c < 6000; c++) begin
      @(negedge CLK);
      if (prev_pend) begin
        chk("hold_valid", 64'(bus.OUT_VALID), 64'd1);
        chk("hold_data", 64'(bus.DATA_OUT), 64'(prev_data));
      end
      if (bus.OUT_VALID && !bus.OUT_READY) chk("in_ready_backpressure", 64'(bus.IN_READY), 64'd0);
      if (bus.OUT_VALID && bus.OUT_READY) begin
        got_q.push_back(bus.DATA_OUT);
        last_take = c;
      end
      prev_pend = bus.OUT_VALID && !bus.OUT_READY;
      prev_data = bus.DATA_OUT;
      if (rmode == 1 && stall_left < 0 && bus.OUT_VALID) stall_left = 10;
      if (done_cnt > 0 && c == done_cyc + 1) begin
        chk("done_pulse_width", 64'(DONE), 64'd0);
        chk("busy_after_done", 64'(BUSY), 64'd0);
        break;
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = c;
        if (chk_lat) chk("done_latency", 64'(done_cyc - last_take), 64'd1);
      end
      @(posedge CLK); #1;
      case (rmode)
        0: bus.OUT_READY = 1'b1;
        1: begin
          if (stall_left > 0) begin
            stall_left--;
            bus.OUT_READY = 1'b0;
          end else begin
            bus.OUT_READY = (stall_left == 0);
          end
        end
        default: bus.OUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic run_frame(input int w, input int h, input int avg, input int kind,
                           input int rmode, input int vrand, input bit chk_lat);
    int n;
    fill(w, h, kind);
    build_expected(w, h, avg);
    bus.OUT_READY = (rmode == 0);
    start_frame(w, h, avg);
    fork
      drive(w * h, w, vrand);
      collect(rmode, chk_lat);
    join
    chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("beat_data", 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic chk_lane0(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] tbl [4];
    logic [DW*NPE-1:0] g;
    tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      chk(tag, 64'(g[DW-1:0]), 64'(tbl[i]));
    end
  endtask

  initial begin
    RESET         = 1'b1;
    START         = 1'b0;
    CFG_ROW_W     = '0;
    CFG_ROWS      = '0;
    CFG_MODE      = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.DATA_IN   = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_in_ready", 64'(bus.IN_READY), 64'd0);
    chk("reset_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("reset_data_out", 64'(bus.DATA_OUT), 64'd0);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    @(posedge CLK); #1;

    run_frame(4, 4, 0, 0, 0, 0, 1'b1);
    chk_lane0("max4x4_lane0", 16'd5, 16'd7, 16'd13, 16'd15);

    run_frame(4, 4, 1, 0, 0, 0, 1'b1);
    chk_lane0("avg4x4_lane0", 16'd2, 16'd4, 16'd10, 16'd12);

    run_frame(2, 2, 1, 2, 0, 0, 1'b1);
    chk("avg_negative_lane0", 64'((got_q.size() > 0) ? got_q[0][DW-1:0] : 16'hxxxx), 64'(16'hfffd));

    run_frame(5, 5, 0, 1, 0, 0, 1'b0);
    chk("trailing_no_stall", 64'(stalls), 64'd0);

    run_frame(4, 4, 0, 1, 1, 0, 1'b1);
    run_frame(16, 16, 1, 1, 2, 1, 1'b1);
    run_frame(16, 16, 0, 1, 2, 1, 1'b1);

    // Abandon a frame mid-way, then a fresh one must see no residue.
    fill(4, 4, 1);
    bus.OUT_READY = 1'b1;
    start_frame(4, 4, 0);
    drive(6, 4, 0);
    #2 RESET = 1'b1;
    #1;
    chk("midreset_in_ready", 64'(bus.IN_READY), 64'd0);
    chk("midreset_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("midreset_data_out", 64'(bus.DATA_OUT), 64'd0);
    chk("midreset_busy", 64'(BUSY), 64'd0);
    chk("midreset_done", 64'(DONE), 64'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;
    run_frame(4, 4, 0, 1, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Parametrised streaming 2-D pooling unit for the PU output path; successor of the fixed 2x2 max-pool stage.
- Accepts raster-order feature-map pixels, NUM_PE independent channels per beat (one lane per PE).
- Emits one pooled pixel per non-overlapping POOL_X x POOL_Y window; window stride equals window size.
- Runtime-selectable MAX or AVG mode, runtime image size, and full valid/ready backpressure on both sides.

Parameters:
- DATA_WIDTH, 16: signed two's-complement lane width.
- NUM_PE, 4: lanes per beat.
- POOL_X, 2: window width; power of 2, 1..8.
- POOL_Y, 2: window height; power of 2, 1..8.
- MAX_OUT_W, 32: maximum pooled row width; sets the row-buffer depth.
- DIM_WIDTH, 10: width of the size config fields.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- START  in  1  pulse; latches the CFG_* inputs; ignored unless IDLE.
- CFG_ROW_W  in  DIM_WIDTH  input pixels per row, >=1.
- CFG_ROWS  in  DIM_WIDTH  input rows, >=1.
- CFG_MODE  in  1  0 = max, 1 = average.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID && IN_READY.
- DATA_IN  in  DATA_WIDTH*NUM_PE  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- OUT_VALID  out  1  pooled beat valid.
- OUT_READY  in  1  downstream accept.
- DATA_OUT  out  DATA_WIDTH*NUM_PE  pooled beat, same lane packing.
- BUSY  out  1  high from START until DONE.
- DONE  out  1  one-cycle pulse after the last output beat is taken.

Behaviour:
- Reset values: IN_READY=0, OUT_VALID=0, DATA_OUT=0, BUSY=0, DONE=0; FSM=IDLE; all counters = 0.
- FSM IDLE -> RUN on START. Latch CFG_*. Compute OUT_W=CFG_ROW_W/POOL_X and OUT_H=CFG_ROWS/POOL_Y (floor).
- FSM RUN -> FLUSH when the last input beat (x=CFG_ROW_W-1, y=CFG_ROWS-1) is accepted.
- FSM FLUSH -> IDLE when the output register is empty; DONE pulses in that same cycle.
- IN_READY = (state==RUN) && (!OUT_VALID || OUT_READY).
- Counters advance only on an accepted beat: x (0..CFG_ROW_W-1), px (0..POOL_X-1), ox, py (0..POOL_Y-1), y.
  - x wraps to 0 at row end and clears px and ox.
  - py wraps after POOL_Y rows.
- Trailing columns (x >= OUT_W*POOL_X) and trailing rows (y >= OUT_H*POOL_Y) are consumed and discarded; no partial windows.
- Accumulator width ACC_W = DATA_WIDTH + log2(POOL_X*POOL_Y).
  - MAX: signed compare.
  - AVG: signed sum.
- Horizontal reduction uses a per-lane register that is seeded on px==0 and combined on later px.
- Vertical reduction uses a row buffer: MAX_OUT_W x NUM_PE x ACC_W flops, indexed by ox.
  - At px==POOL_X-1: py==0 writes the buffer; 0<py<POOL_Y-1 combines into it; py==POOL_Y-1 combines with the buffer and loads the output register.
- AVG result = sum arithmetically shifted right by log2(POOL_X*POOL_Y), i.e. rounding toward -inf. MAX result = max. Both are truncated to DATA_WIDTH.
- POOL_X==POOL_Y==1 is a pass-through with registered latency.
- Latency: OUT_VALID rises the cycle after the window's final beat is accepted.
- Output register holds DATA_OUT stable while OUT_VALID && !OUT_READY. It loads the new result on the same edge it is drained.
- Simultaneous output drain and new window completion: no bubble, full throughput of 1 beat/cycle.
- If OUT_W > MAX_OUT_W, columns with ox >= MAX_OUT_W are discarded. This is a configuration error, not checked.
- START while BUSY is ignored; config changes mid-frame have no effect.
- RESET mid-frame (asynchronous): the partial frame is abandoned, outputs go to reset values, no DONE. The row buffer need not be cleared.

Decomposition:
- Package pool_pkg holds: MODE_MAX/MODE_AVG constants, FSM state encoding (IDLE/RUN/FLUSH), the ACC_W function, and the clog2 helper.
- One sub-module, pool_lane_alu: per-lane combine (max or add, width ACC_W), plus the final shift/truncate. Instantiated NUM_PE times in a generate loop.
- Counters and FSM are in the top level.

Test Plan:
- 4x4 image, 2x2, MAX, NUM_PE=4, lane values = pixel index (0..15) -> 4 beats per lane: 5, 7, 13, 15; DONE one cycle after the 4th is taken.
- Same image, AVG mode -> 2, 4, 10, 12 (sums 10, 18, 42, 50, each >>2).
- AVG with negatives: window {-1, -2, -3, -4} -> -3 (sum -10 >>> 2; rounding toward -inf).
- 5x5 image, 2x2, MAX -> exactly 4 outputs; column 4 and row 4 are discarded; IN_READY stays high for all 25 beats.
- OUT_READY held low 10 cycles with an output pending -> IN_READY=0, DATA_OUT stable. On release, no lost or duplicated beats; randomised OUT_READY over a 16x16 frame is checked against a software model.
- Assert RESET after 6 of 16 beats, then START with a fresh 4x4 frame -> correct 4 outputs; no stale row-buffer effect; single DONE.
